// File: rtl/fetch_unit.sv
// IF stage: PC register, imem request/ready handshake and IF/ID register.
// Tracks in-flight fetches across wait states, stalls and redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcsrc,
  input  logic [31:0] pc_addr,
  input  logic        IFID_flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ID_instruction,
  output logic [31:0] ID_pcplus4,
  output logic        ID_valid
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DISCARD,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] hinstr_q, hinstr_d;
  logic [31:0] hpc4_q, hpc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] tgt;
  logic [31:0] pc_inc;
  logic        bub;
  logic        dlv;
  logic [31:0] dlv_instr;
  logic [31:0] dlv_pc4;

  assign tgt    = {pc_addr[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      redir_q  <= '0;
      hinstr_q <= '0;
      hpc4_q   <= '0;
      instr_q  <= NOP;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      redir_q  <= redir_d;
      hinstr_q <= hinstr_d;
      hpc4_q   <= hpc4_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    redir_d   = redir_q;
    hinstr_d  = hinstr_q;
    hpc4_d    = hpc4_q;
    bub       = 1'b0;
    dlv       = 1'b0;
    dlv_instr = imem_rdata;
    dlv_pc4   = pc_inc;
    unique case (state_q)
      BOOT: begin
        bub     = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (stall) begin
          if (imem_ready) begin
            hinstr_d = imem_rdata;
            hpc4_d   = pc_inc;
            pc_d     = pc_inc;
            state_d  = HOLD;
          end
        end else if (pcsrc) begin
          bub = 1'b1;
          if (imem_ready) begin
            pc_d = tgt;
          end else begin
            redir_d = tgt;
            state_d = DISCARD;
          end
        end else if (IFID_flush) begin
          // Squash without redirect: refetch the same pc.
          bub = 1'b1;
        end else if (imem_ready) begin
          dlv  = 1'b1;
          pc_d = pc_inc;
        end else begin
          bub = 1'b1;
        end
      end
      DISCARD: begin
        if (!stall) begin
          bub = 1'b1;
          if (pcsrc) redir_d = tgt;
        end
        if (imem_ready) begin
          pc_d    = (!stall && pcsrc) ? tgt : redir_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (!stall) begin
          if (pcsrc) begin
            bub     = 1'b1;
            pc_d    = tgt;
            state_d = FETCH;
          end else if (IFID_flush) begin
            bub = 1'b1;
          end else begin
            dlv       = 1'b1;
            dlv_instr = hinstr_q;
            dlv_pc4   = hpc4_q;
            state_d   = FETCH;
          end
        end
      end
      default: begin
        bub     = 1'b1;
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bub) begin
      instr_d = NOP;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (dlv) begin
      instr_d = dlv_instr;
      pc4_d   = dlv_pc4;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    imem_req = (state_q == FETCH) || (state_q == DISCARD);
  end

  assign imem_addr      = pc_q;
  assign ID_instruction = instr_q;
  assign ID_pcplus4     = pc4_q;
  assign ID_valid       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns addr ^ 32'hDEAD_0000.
// Expected values are hand-computed per step.
module tb_fetch_unit;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcsrc;
  logic [31:0] pc_addr;
  logic        IFID_flush;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] ID_instruction;
  logic [31:0] ID_pcplus4;
  logic        ID_valid;

  int n_run  = 0;
  int n_fail = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP     (NOPW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pcsrc         (pcsrc),
    .pc_addr       (pc_addr),
    .IFID_flush    (IFID_flush),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .ID_instruction(ID_instruction),
    .ID_pcplus4    (ID_pcplus4),
    .ID_valid      (ID_valid)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v,
                        input logic [31:0] ins, input logic [31:0] p4);
    chk({tag, ".valid"}, {31'b0, ID_valid}, {31'b0, v});
    chk({tag, ".instr"}, ID_instruction, ins);
    chk({tag, ".pc4"}, ID_pcplus4, p4);
  endtask

  task automatic chk_if(input string tag, input logic r,
                        input logic [31:0] a);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, r});
    chk({tag, ".addr"}, imem_addr, a);
  endtask

  initial begin
    rst        = 1'b1;
    pcsrc      = 1'b0;
    pc_addr    = '0;
    IFID_flush = 1'b0;
    stall      = 1'b0;
    imem_ready = 1'b1;
    step();
    step();
    chk_if("rst", 1'b0, 32'h0);
    chk_id("rst", 1'b0, NOPW, 32'h0);

    // Boot and sequential fetch
    rst = 1'b0;
    chk_if("boot", 1'b0, 32'h0);
    step();
    chk_if("f0", 1'b1, 32'h0);
    chk_id("f0", 1'b0, NOPW, 32'h0);
    step();
    chk_if("f1", 1'b1, 32'h4);
    chk_id("f1", 1'b1, 32'hDEAD_0000, 32'h4);
    step();
    chk_if("f2", 1'b1, 32'h8);
    chk_id("f2", 1'b1, 32'hDEAD_0004, 32'h8);

    // Taken branch, misaligned target gets aligned
    pcsrc = 1'b1; IFID_flush = 1'b1; pc_addr = 32'h41;
    step();
    pcsrc = 1'b0; IFID_flush = 1'b0;
    chk_if("br", 1'b1, 32'h40);
    chk_id("br", 1'b0, NOPW, 32'h0);
    step();
    chk_if("br1", 1'b1, 32'h44);
    chk_id("br1", 1'b1, 32'hDEAD_0040, 32'h44);

    // Redirect during wait states
    imem_ready = 1'b0;
    pcsrc = 1'b1; IFID_flush = 1'b1; pc_addr = 32'h80;
    step();
    pcsrc = 1'b0; IFID_flush = 1'b0;
    chk_if("w0", 1'b1, 32'h44);
    chk_id("w0", 1'b0, NOPW, 32'h0);
    step();
    chk_if("w1", 1'b1, 32'h44);
    chk_id("w1", 1'b0, NOPW, 32'h0);
    step();
    chk_if("w2", 1'b1, 32'h44);
    imem_ready = 1'b1;
    step();
    chk_if("w3", 1'b1, 32'h80);
    chk_id("w3", 1'b0, NOPW, 32'h0);
    step();
    chk_if("w4", 1'b1, 32'h84);
    chk_id("w4", 1'b1, 32'hDEAD_0080, 32'h84);

    // Stall with fetch: get a valid word in ID, then stall at pc 0x10
    pcsrc = 1'b1; IFID_flush = 1'b1; pc_addr = 32'h0C;
    step();
    pcsrc = 1'b0; IFID_flush = 1'b0;
    chk_if("s_pre", 1'b1, 32'h0C);
    step();
    chk_if("s_pre1", 1'b1, 32'h10);
    chk_id("s_pre1", 1'b1, 32'hDEAD_000C, 32'h10);
    stall = 1'b1;
    step();
    chk_if("s0", 1'b0, 32'h14);
    chk_id("s0", 1'b1, 32'hDEAD_000C, 32'h10);
    pcsrc = 1'b1; IFID_flush = 1'b1; pc_addr = 32'h200;
    step();
    chk_id("s1", 1'b1, 32'hDEAD_000C, 32'h10);
    step();
    chk_if("s2", 1'b0, 32'h14);
    chk_id("s2", 1'b1, 32'hDEAD_000C, 32'h10);
    stall = 1'b0; pcsrc = 1'b0; IFID_flush = 1'b0;
    step();
    chk_if("s3", 1'b1, 32'h14);
    chk_id("s3", 1'b1, 32'hDEAD_0010, 32'h14);
    step();
    chk_if("s4", 1'b1, 32'h18);
    chk_id("s4", 1'b1, 32'hDEAD_0014, 32'h18);

    // HOLD then redirect on release
    stall = 1'b1;
    step();
    chk_if("h0", 1'b0, 32'h1C);
    stall = 1'b0; pcsrc = 1'b1; IFID_flush = 1'b1; pc_addr = 32'h100;
    step();
    pcsrc = 1'b0; IFID_flush = 1'b0;
    chk_if("h1", 1'b1, 32'h100);
    chk_id("h1", 1'b0, NOPW, 32'h0);
    step();
    chk_id("h2", 1'b1, 32'hDEAD_0100, 32'h104);

    // PC wrap
    pcsrc = 1'b1; IFID_flush = 1'b1; pc_addr = 32'hFFFF_FFFC;
    step();
    pcsrc = 1'b0; IFID_flush = 1'b0;
    chk_if("wr0", 1'b1, 32'hFFFF_FFFC);
    step();
    chk_if("wr1", 1'b1, 32'h0);
    chk_id("wr1", 1'b1, 32'h2152_FFFC, 32'h0);
    step();
    chk_if("wr2", 1'b1, 32'h4);

    // Async reset mid-DISCARD
    imem_ready = 1'b0;
    pcsrc = 1'b1; IFID_flush = 1'b1; pc_addr = 32'h300;
    step();
    pcsrc = 1'b0; IFID_flush = 1'b0;
    chk_if("d0", 1'b1, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk_if("arst", 1'b0, 32'h0);
    chk_id("arst", 1'b0, NOPW, 32'h0);
    imem_ready = 1'b1;
    step();
    rst = 1'b0;
    chk_if("rb0", 1'b0, 32'h0);
    step();
    chk_if("rb1", 1'b1, 32'h0);
    step();
    chk_id("rb2", 1'b1, 32'hDEAD_0000, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
